led_pattern_sequencer: RTL and testbench
========================================

// Module: led_pattern_sequencer
// PURPOSE
//  Parametrised LED pattern engine: divides clk into a programmable step tick; on each tick,
//  advances a WIDTH-bit pattern in one of four modes (rotate left/right, bounce, binary count).
//  Sits between the board clock and the LED pins; seed, mode, rate and enable are runtime inputs.
// PARAMETERS
//  WIDTH        4            pattern/LED width, >=1
//  COUNT_WIDTH  32           width of step-period counter and period input
//  SEED         4'b0011      reset value of pattern (WIDTH bits, zero-extended/truncated)
// PORTS
//  clk      in   1            system clock
//  rst      in   1            asynchronous reset, active-high
//  enable   in   1            1 = tick counter runs; 0 = counter and pattern hold
//  period   in   COUNT_WIDTH  clk cycles per step; 0 treated as 1
//  mode     in   2            led_seq_pkg::mode_e: ROT_L=0, ROT_R=1, BOUNCE=2, COUNT=3
//  load     in   1            synchronous load of seed_in (priority over tick)
//  seed_in  in   WIDTH        value loaded on load
//  duty     in   8            PWM brightness (only used with LED_SEQ_PWM_EN)
//  out      out  WIDTH        LED drive
//  step     out  1            one-cycle pulse in the cycle pattern updates
// BEHAVIOUR
//  - Reset (async, rst=1): cnt=0, pat=SEED, dir=LEFT, step=0, out=SEED (PWM: out=0).
//  - Tick: when enable=1 and cnt >= eff_period-1 (eff_period = period ? period : 1): cnt<=0,
//    tick=1; else if enable=1: cnt<=cnt+1. enable=0: cnt holds, no tick.
//  - Period lowered mid-run below current cnt: ">=" compare forces tick next cycle, no long wrap.
//  - On tick, pat updates at that clock edge; step registered high for exactly that cycle.
//    Latency: pattern visible on out in the cycle after the tick-condition cycle.
//  - ROT_L: pat <= {pat[W-2:0], pat[W-1]}. ROT_R: pat <= {pat[0], pat[W-1:1]}.
//  - BOUNCE: dir=LEFT: if pat[W-1] then dir<=RIGHT and shift right, else shift left (zero fill);
//    dir=RIGHT mirrored on pat[0]. Reversal and move happen on the same tick (no dwell).
//  - COUNT: pat <= pat + 1, wraps modulo 2^WIDTH.
//  - WIDTH=1: rotate/bounce leave pat unchanged; COUNT toggles.
//  - pat==0: rotate/bounce stay 0; COUNT proceeds.
//  - load=1: pat<=seed_in, cnt<=0, dir<=LEFT, step=0; overrides a coincident tick.
//  - Mode change: applied on next tick; dir retained; no pattern glitch.
//  - Reset mid-operation returns immediately to reset state regardless of clk.
// CONFIGURATION
//  LED_SEQ_PWM_EN defined: 8-bit free-running pwm_cnt (reset 0, +1 every clk);
//    out = pat & {WIDTH{pwm_cnt < duty}} registered; duty=0 -> dark, duty=255 -> on 255/256.
//  Undefined: out = pat directly; duty ignored; no pwm counter in netlist.
// STRUCTURE
//  led_seq_pkg: typedef enum logic [1:0] mode_e {ROT_L,ROT_R,BOUNCE,COUNT}; dir_e {LEFT,RIGHT}.
//  Sub-module step_tick_gen (cnt, eff_period, enable -> tick); top holds pat/dir/step/PWM.
// TESTING (WIDTH=4, SEED=4'b0011, enable=1 unless noted)
//  1 Reset, period=4, ROT_L: out 0011 -> 0110 -> 1100 -> 1001 -> 0011, step every 4 clks.
//  2 ROT_R, period=0: pattern steps every clk: 0011 -> 1001 -> 1100; step held high continuously.
//  3 load seed_in=0001, BOUNCE, period=1: 0001,0010,0100,1000,0100,0010,0001,0010.
//  4 COUNT, load 1110, period=2: 1110 -> 1111 -> 0000 (wrap) -> 0001.
//  5 enable=0 for 10 clks mid-count then 1: out frozen, next step exactly at remaining cnt.
//  6 load and tick same cycle -> out=seed_in, step=0; rst pulsed mid-run -> out=0011 at once.
//  (PWM build) duty=64 -> out high 64 of every 256 clks; duty=0 -> out always 0.

Source files
------------

// File: rtl/led_seq_pkg.sv
// Shared types for the LED pattern sequencer: advance modes and bounce direction.
package led_seq_pkg;

  typedef enum logic [1:0] {
    ROT_L  = 2'd0,
    ROT_R  = 2'd1,
    BOUNCE = 2'd2,
    COUNT  = 2'd3
  } mode_e;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } dir_e;

  localparam int unsigned PWM_WIDTH = 8;

endpackage

// File: rtl/step_tick_gen.sv
// Step-period divider: produces a one-cycle tick_c every eff_period enabled clocks.
module step_tick_gen #(
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   clear,
  input  logic [COUNT_WIDTH-1:0] period,
  output logic                   tick_c
);

  logic [COUNT_WIDTH-1:0] cnt;
  logic [COUNT_WIDTH-1:0] cnt_nxt;
  logic [COUNT_WIDTH-1:0] eff_period;

  assign eff_period = (period == '0) ? COUNT_WIDTH'(1) : period;

  // ">=" so a period lowered below the running count fires at once instead of wrapping
  assign tick_c = enable && (cnt >= (eff_period - COUNT_WIDTH'(1)));

  always_comb begin
    cnt_nxt = cnt;
    if (clear || tick_c) begin
      cnt_nxt = '0;
    end else if (enable) begin
      cnt_nxt = cnt + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/led_pattern_sequencer.sv
// LED pattern engine: rotates, bounces or counts a WIDTH-bit pattern on each step tick.
// Optional PWM brightness stage enabled by defining LED_SEQ_PWM_EN.
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int unsigned      WIDTH       = 4,
  parameter int unsigned      COUNT_WIDTH = 32,
  parameter logic [WIDTH-1:0] SEED        = WIDTH'(4'b0011)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [COUNT_WIDTH-1:0] period,
  input  logic [1:0]             mode,
  input  logic                   load,
  input  logic [WIDTH-1:0]       seed_in,
  input  logic [7:0]             duty,
  output logic [WIDTH-1:0]       out,
  output logic                   step
);

  logic             tick_c;
  logic [WIDTH-1:0] pat;
  logic [WIDTH-1:0] pat_nxt;
  logic [WIDTH-1:0] rol;
  logic [WIDTH-1:0] ror;
  dir_e             dir;
  dir_e             dir_nxt;
  logic             step_nxt;

  step_tick_gen #(
    .COUNT_WIDTH(COUNT_WIDTH)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .clear  (load),
    .period (period),
    .tick_c (tick_c)
  );

  // Shift-based rotates degenerate to identity when WIDTH is 1
  assign rol = (pat << 1) | (pat >> (WIDTH - 1));
  assign ror = (pat >> 1) | (pat << (WIDTH - 1));

  // Next pattern/direction; load wins over a coincident tick
  always_comb begin
    pat_nxt  = pat;
    dir_nxt  = dir;
    step_nxt = 1'b0;
    if (load) begin
      pat_nxt = seed_in;
      dir_nxt = LEFT;
    end else if (tick_c) begin
      step_nxt = 1'b1;
      case (mode_e'(mode))
        ROT_L:  pat_nxt = rol;
        ROT_R:  pat_nxt = ror;
        BOUNCE: begin
          if (WIDTH > 1) begin
            if (dir == LEFT) begin
              if (pat[WIDTH-1]) begin
                dir_nxt = RIGHT;
                pat_nxt = pat >> 1;
              end else begin
                pat_nxt = pat << 1;
              end
            end else begin
              if (pat[0]) begin
                dir_nxt = LEFT;
                pat_nxt = pat << 1;
              end else begin
                pat_nxt = pat >> 1;
              end
            end
          end
        end
        COUNT:   pat_nxt = pat + WIDTH'(1);
        default: pat_nxt = pat;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat  <= SEED;
      dir  <= LEFT;
      step <= 1'b0;
    end else begin
      pat  <= pat_nxt;
      dir  <= dir_nxt;
      step <= step_nxt;
    end
  end

`ifdef LED_SEQ_PWM_EN
  logic [PWM_WIDTH-1:0] pwm_cnt;
  logic [WIDTH-1:0]     out_q;

  // Free-running PWM phase; duty of 255 leaves one dark slot per 256 clocks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt <= '0;
      out_q   <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_WIDTH'(1);
      out_q   <= pat & {WIDTH{pwm_cnt < duty}};
    end
  end

  assign out = out_q;
`else
  logic unused_duty;

  assign unused_duty = ^duty;
  assign out         = pat;
`endif

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed scoreboard bench for led_pattern_sequencer (default build, WIDTH=4, SEED=4'b0011).
module tb_led_pattern_sequencer;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [31:0] period;
  logic [1:0]  mode;
  logic        load;
  logic [3:0]  seed_in;
  logic [7:0]  duty;
  logic [3:0]  out;
  logic        step;

  logic [4:0]  sb[$];
  int          vectors;
  int          miscompares;
  string       tag;

  led_pattern_sequencer #(
    .WIDTH(4),
    .COUNT_WIDTH(32),
    .SEED(4'b0011)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .period  (period),
    .mode    (mode),
    .load    (load),
    .seed_in (seed_in),
    .duty    (duty),
    .out     (out),
    .step    (step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input logic [3:0] o, input logic s);
    sb.push_back({o, s});
  endtask

  // quiet cycles holding q_out with step low, then one step cycle showing s_out
  task automatic seg(input int quiet, input logic [3:0] q_out, input logic [3:0] s_out);
    for (int i = 0; i < quiet; i++) push(q_out, 1'b0);
    push(s_out, 1'b1);
  endtask

  task automatic check_one();
    logic [4:0] e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL %s: scoreboard empty, observed out/step %b/%b", tag, out, step);
    end else begin
      e = sb.pop_front();
      assert ({out, step} === e) else begin
        miscompares++;
        $error("FAIL %s: out/step observed %b/%b expected %b/%b", tag, out, step, e[4:1], e[0]);
      end
    end
  endtask

  task automatic clk_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check_one();
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst     = 1'b1;
    enable  = 1'b1;
    period  = 32'd4;
    mode    = 2'd0;
    load    = 1'b0;
    seed_in = 4'b0000;
    duty    = 8'd0;

    tag = "reset";
    #12;
    push(4'b0011, 1'b0);
    check_one();
    rst = 1'b0;

    tag = "rot_l_p4";
    seg(3, 4'b0011, 4'b0110);
    seg(3, 4'b0110, 4'b1100);
    seg(3, 4'b1100, 4'b1001);
    seg(3, 4'b1001, 4'b0011);
    clk_check(16);

    tag = "rot_r_p0";
    mode   = 2'd1;
    period = 32'd0;
    seg(0, 4'b0000, 4'b1001);
    seg(0, 4'b0000, 4'b1100);
    seg(0, 4'b0000, 4'b0110);
    clk_check(3);

    tag = "bounce_p1";
    mode    = 2'd2;
    period  = 32'd1;
    load    = 1'b1;
    seed_in = 4'b0001;
    push(4'b0001, 1'b0);
    clk_check(1);
    load = 1'b0;
    seg(0, 4'b0000, 4'b0010);
    seg(0, 4'b0000, 4'b0100);
    seg(0, 4'b0000, 4'b1000);
    seg(0, 4'b0000, 4'b0100);
    seg(0, 4'b0000, 4'b0010);
    seg(0, 4'b0000, 4'b0001);
    seg(0, 4'b0000, 4'b0010);
    clk_check(7);

    tag = "count_wrap_p2";
    mode    = 2'd3;
    period  = 32'd2;
    load    = 1'b1;
    seed_in = 4'b1110;
    push(4'b1110, 1'b0);
    clk_check(1);
    load = 1'b0;
    seg(1, 4'b1110, 4'b1111);
    seg(1, 4'b1111, 4'b0000);
    seg(1, 4'b0000, 4'b0001);
    clk_check(6);

    tag = "enable_hold";
    period = 32'd4;
    push(4'b0001, 1'b0);
    push(4'b0001, 1'b0);
    clk_check(2);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) push(4'b0001, 1'b0);
    clk_check(10);
    enable = 1'b1;
    seg(1, 4'b0001, 4'b0010);
    clk_check(2);

    tag = "load_vs_tick";
    period  = 32'd1;
    load    = 1'b1;
    seed_in = 4'b0101;
    push(4'b0101, 1'b0);
    clk_check(1);
    load = 1'b0;
    seg(0, 4'b0000, 4'b0110);
    clk_check(1);

    tag = "async_reset";
    rst = 1'b1;
    #1;
    push(4'b0011, 1'b0);
    check_one();
    period = 32'd8;
    #1;
    rst = 1'b0;

    tag = "period_lowered";
    for (int i = 0; i < 5; i++) push(4'b0011, 1'b0);
    clk_check(5);
    period = 32'd2;
    seg(0, 4'b0000, 4'b0100);
    seg(1, 4'b0100, 4'b0101);
    clk_check(3);

    tag = "rot_zero";
    mode    = 2'd0;
    period  = 32'd1;
    load    = 1'b1;
    seed_in = 4'b0000;
    push(4'b0000, 1'b0);
    clk_check(1);
    load = 1'b0;
    seg(0, 4'b0000, 4'b0000);
    seg(0, 4'b0000, 4'b0000);
    clk_check(2);

    tag = "scoreboard_drain";
    vectors++;
    assert (sb.size() === 0) else begin
      miscompares++;
      $error("FAIL %s: %0d entries left, expected 0", tag, sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
